// File: rtl/alu_selftest_sched.sv
// alu_selftest_sched
//   Online self-test scheduler for a bank of NREP voted ALU replicas.
//   The processor always owns the replica operand bus when it is active.
//   Once the processor has been idle for IDLE_WAIT cycles (and test_en is
//   high) the block drives LFSR-based test vectors into every replica,
//   compares each replica against a built-in golden ALU model, and removes
//   replicas that fail FAIL_LIMIT vectors in a row from the vote. A disable
//   is refused if it would leave fewer than MIN_ALIVE replicas voting.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   i_cpu_valid        processor drives the ALU this cycle
//   i_cpu_a/_b/_alucont processor operands and ALU control
//   i_test_en          self-test permitted
//   o_alu_a/_b/_cont   operands/control to all replicas
//   o_cpu_owns         bank is driven by the processor
//   i_rep_result       replica i result at [32i+31:32i]
//   i_rep_zero         replica zero flags
//   o_rep_enable       sticky per-replica vote enable
//   o_fault_cnt        number of disabled replicas
//   o_degraded         sticky: a disable was refused to keep MIN_ALIVE voters
//   o_vec_cnt          completed test vectors, saturating
//
// State table
//   S_WAIT | counting consecutive idle cycles before testing
//   S_TEST | one test vector applied and checked per idle cycle

module alu_selftest_sched #(
  parameter int          NREP       = 8,
  parameter int          IDLE_WAIT  = 4,
  parameter int          FAIL_LIMIT = 2,
  parameter int          MIN_ALIVE  = 3,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12345
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cpu_valid,
  input  logic [31:0]        i_cpu_a,
  input  logic [31:0]        i_cpu_b,
  input  logic [2:0]         i_cpu_alucont,
  input  logic               i_test_en,
  output logic [31:0]        o_alu_a,
  output logic [31:0]        o_alu_b,
  output logic [2:0]         o_alu_cont,
  output logic               o_cpu_owns,
  input  logic [NREP*32-1:0] i_rep_result,
  input  logic [NREP-1:0]    i_rep_zero,
  output logic [NREP-1:0]    o_rep_enable,
  output logic [3:0]         o_fault_cnt,
  output logic               o_degraded,
  output logic [15:0]        o_vec_cnt
);

  localparam int IW = (IDLE_WAIT > 1) ? $clog2(IDLE_WAIT) : 1;
  localparam int NW = $clog2(NREP + 1);

  typedef enum logic {S_WAIT, S_TEST} state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idle_cnt;
  logic [31:0]    r_lfsr;
  logic [2:0]     r_op_idx;
  logic [1:0]     r_mcnt [NREP];
  logic [NREP-1:0] r_rep_enable;
  logic           r_degraded;
  logic [15:0]    r_vec_cnt;

  logic [31:0]    w_tv_a;
  logic [31:0]    w_tv_b;
  logic [2:0]     w_tv_cont;
  logic [31:0]    w_b2;
  logic [31:0]    w_sum;
  logic [31:0]    w_gold;
  logic           w_gzero;
  logic [NREP-1:0] w_mis;
  logic [NREP-1:0] w_cand;
  logic [1:0]     w_cnt_nxt [NREP];
  logic [NW-1:0]  w_n_en;
  logic [NW-1:0]  w_n_cand;
  logic           w_keep;
  logic [3:0]     w_n_fault;
  logic           w_idle;

  // Test vector and golden model
  always_comb begin
    w_tv_a = r_lfsr;
    w_tv_b = {r_lfsr[15:0], r_lfsr[31:16]};
    case (r_op_idx)
      3'd0:    w_tv_cont = 3'b010;
      3'd1:    w_tv_cont = 3'b110;
      3'd2:    w_tv_cont = 3'b000;
      3'd3:    w_tv_cont = 3'b001;
      3'd4:    w_tv_cont = 3'b111;
      default: w_tv_cont = 3'b010;
    endcase
    w_b2  = w_tv_cont[2] ? ~w_tv_b : w_tv_b;
    w_sum = w_tv_a + w_b2 + {31'b0, w_tv_cont[2]};
    case (w_tv_cont[1:0])
      2'b00:   w_gold = w_tv_a & w_tv_b;
      2'b01:   w_gold = w_tv_a | w_tv_b;
      2'b10:   w_gold = w_sum;
      default: w_gold = {31'b0, w_sum[31]};
    endcase
    w_gzero = (w_gold == 32'd0);
  end

  // Per-replica check; disabled replicas are still tracked but never candidates
  always_comb begin
    w_n_en    = '0;
    w_n_cand  = '0;
    w_n_fault = '0;
    w_mis     = '0;
    w_cand    = '0;
    for (int i = 0; i < NREP; i++) begin
      w_mis[i] = (i_rep_result[32*i +: 32] != w_gold) || (i_rep_zero[i] != w_gzero);
      if (w_mis[i])
        w_cnt_nxt[i] = (r_mcnt[i] == 2'(FAIL_LIMIT)) ? r_mcnt[i] : r_mcnt[i] + 2'd1;
      else
        w_cnt_nxt[i] = 2'd0;
      w_cand[i] = r_rep_enable[i] && w_mis[i] && (r_mcnt[i] == 2'(FAIL_LIMIT - 1));
      w_n_en    = w_n_en + NW'(r_rep_enable[i]);
      w_n_cand  = w_n_cand + NW'(w_cand[i]);
      w_n_fault = w_n_fault + 4'(!r_rep_enable[i]);
    end
    // candidates never exceed enabled replicas, so the subtraction cannot wrap
    w_keep = (w_n_en - w_n_cand) >= NW'(MIN_ALIVE);
  end

  assign w_idle = !i_cpu_valid && i_test_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT;
      r_idle_cnt   <= '0;
      r_lfsr       <= LFSR_SEED;
      r_op_idx     <= 3'd0;
      for (int i = 0; i < NREP; i++) r_mcnt[i] <= 2'd0;
      r_rep_enable <= '1;
      r_degraded   <= 1'b0;
      r_vec_cnt    <= 16'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (!w_idle) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IW'(IDLE_WAIT - 1)) begin
            r_state    <= S_TEST;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end
        S_TEST: begin
          if (!w_idle) begin
            // vector abandoned: lfsr/op_idx hold so it is retried later
            r_state    <= S_WAIT;
            r_idle_cnt <= '0;
          end else begin
            r_lfsr    <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
            r_op_idx  <= (r_op_idx == 3'd4) ? 3'd0 : r_op_idx + 3'd1;
            r_vec_cnt <= (r_vec_cnt == 16'hFFFF) ? r_vec_cnt : r_vec_cnt + 16'd1;
            for (int i = 0; i < NREP; i++) r_mcnt[i] <= w_cnt_nxt[i];
            if (w_keep) r_rep_enable <= r_rep_enable & ~w_cand;
            else        r_degraded   <= 1'b1;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // Operand mux: processor first, then test vector, else quiet bus
  always_comb begin
    o_alu_a    = 32'd0;
    o_alu_b    = 32'd0;
    o_alu_cont = 3'd0;
    if (i_cpu_valid) begin
      o_alu_a    = i_cpu_a;
      o_alu_b    = i_cpu_b;
      o_alu_cont = i_cpu_alucont;
    end else if (r_state == S_TEST && i_test_en) begin
      o_alu_a    = w_tv_a;
      o_alu_b    = w_tv_b;
      o_alu_cont = w_tv_cont;
    end
  end

  assign o_cpu_owns   = i_cpu_valid;
  assign o_rep_enable = r_rep_enable;
  assign o_fault_cnt  = w_n_fault;
  assign o_degraded   = r_degraded;
  assign o_vec_cnt    = r_vec_cnt;

endmodule

// File: tb/tb_alu_selftest_sched.sv
// Self-checking bench for alu_selftest_sched: directed scenarios plus a
// randomized run, all compared against a behavioural scheduler model.
module tb_alu_selftest_sched;

  localparam int NREP = 8;
  localparam int IDLE_WAIT = 4;
  localparam int FAIL_LIMIT = 2;
  localparam int MIN_ALIVE = 3;
  localparam logic [31:0] SEED = 32'hACE12345;

  logic clk, reset, cpu_valid, test_en;
  logic [31:0] cpu_a, cpu_b;
  logic [2:0] cpu_alucont;
  logic [31:0] alu_a, alu_b;
  logic [2:0] alu_cont;
  logic cpu_owns;
  logic [NREP*32-1:0] rep_result;
  logic [NREP-1:0] rep_zero, rep_enable;
  logic [3:0] fault_cnt;
  logic degraded;
  logic [15:0] vec_cnt;

  int n_checks = 0;
  int n_fail = 0;

  alu_selftest_sched #(.NREP(NREP), .IDLE_WAIT(IDLE_WAIT), .FAIL_LIMIT(FAIL_LIMIT),
                       .MIN_ALIVE(MIN_ALIVE), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .i_cpu_valid(cpu_valid), .i_cpu_a(cpu_a),
    .i_cpu_b(cpu_b), .i_cpu_alucont(cpu_alucont), .i_test_en(test_en),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cont(alu_cont), .o_cpu_owns(cpu_owns),
    .i_rep_result(rep_result), .i_rep_zero(rep_zero), .o_rep_enable(rep_enable),
    .o_fault_cnt(fault_cnt), .o_degraded(degraded), .o_vec_cnt(vec_cnt));

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [2:0] OPS [5];
  bit m_test;
  int m_idle, m_op, m_vec;
  logic [31:0] m_lfsr;
  int m_cnt [NREP];
  logic [7:0] m_en;
  bit m_deg;
  int kind [NREP];  // 0 = correct, 1 = inverted result, 2 = wrong zero flag

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    logic [31:0] s;
    s = c[2] ? (a - b) : (a + b);
    case (c[1:0])
      2'b00: return a & b;
      2'b01: return a | b;
      2'b10: return s;
      default: return {31'b0, s[31]};
    endcase
  endfunction

  function automatic logic [31:0] m_b();
    return {m_lfsr[15:0], m_lfsr[31:16]};
  endfunction

  function automatic logic [31:0] exp_a();
    if (cpu_valid) return cpu_a;
    if (m_test && test_en) return m_lfsr;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_b();
    if (cpu_valid) return cpu_b;
    if (m_test && test_en) return m_b();
    return 32'd0;
  endfunction

  function automatic logic [2:0] exp_cont();
    if (cpu_valid) return cpu_alucont;
    if (m_test && test_en) return OPS[m_op];
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_test = 0; m_idle = 0; m_op = 0; m_vec = 0; m_lfsr = SEED;
    m_en = 8'hFF; m_deg = 0;
    for (int i = 0; i < NREP; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    logic [7:0] cand;
    if (!m_test) begin
      if (cpu_valid || !test_en) m_idle = 0;
      else if (m_idle == IDLE_WAIT - 1) begin m_test = 1; m_idle = 0; end
      else m_idle++;
    end else if (cpu_valid || !test_en) begin
      m_test = 0; m_idle = 0;
    end else begin
      cand = 0;
      for (int i = 0; i < NREP; i++) begin
        if (kind[i] != 0) begin
          if (m_en[i] && m_cnt[i] + 1 == FAIL_LIMIT) cand[i] = 1;
          m_cnt[i] = (m_cnt[i] + 1 > FAIL_LIMIT) ? FAIL_LIMIT : m_cnt[i] + 1;
        end else m_cnt[i] = 0;
      end
      if ($countones(m_en) - $countones(cand) >= MIN_ALIVE) m_en = m_en & ~cand;
      else m_deg = 1;
      m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
      m_op = (m_op + 1) % 5;
      if (m_vec < 65535) m_vec++;
    end
  endtask

  // drive processor/test inputs and replica answers for the model's current vector
  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] c, input bit te);
    logic [31:0] g, r;
    cpu_valid = v; cpu_a = a; cpu_b = b; cpu_alucont = c; test_en = te;
    g = golden(m_lfsr, m_b(), OPS[m_op]);
    for (int i = 0; i < NREP; i++) begin
      r = (kind[i] == 1) ? ~g : g;
      rep_result[32*i +: 32] = r;
      rep_zero[i] = (kind[i] == 2) ? (r != 0) : (r == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin drive(0, 0, 0, 0, 1); step(); end
  endtask

  task automatic assert_reset();
    reset = 1;
    model_reset();
    for (int i = 0; i < NREP; i++) kind[i] = 0;
    drive(0, 0, 0, 0, 1);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset();
    n_checks++; if (rep_enable !== 8'hFF) begin n_fail++; $display("FAIL reset_en: got %h expected ff", rep_enable); end
    n_checks++; if (vec_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_vec: got %0d expected 0", vec_cnt); end
    n_checks++; if (degraded !== 1'b0) begin n_fail++; $display("FAIL reset_deg: got %b expected 0", degraded); end
    n_checks++; if (fault_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_fcnt: got %0d expected 0", fault_cnt); end
    n_checks++; if (alu_a !== 32'd0 || cpu_owns !== 1'b0) begin n_fail++; $display("FAIL reset_bus: alu_a %h owns %b expected 0/0", alu_a, cpu_owns); end
    release_reset();
  endtask

  task automatic test_first_vector();
    for (int c = 0; c < 24; c++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      n_checks++;
      if (c < 4 && alu_a !== 32'd0) begin n_fail++; $display("FAIL idle_bus c%0d: got %h expected 0", c, alu_a); end
      else if (c == 4 && (alu_a !== 32'hACE12345 || alu_cont !== 3'b010)) begin
        n_fail++; $display("FAIL first_vec: got %h/%b expected ace12345/010", alu_a, alu_cont);
      end else if (alu_a !== exp_a() || alu_b !== exp_b() || alu_cont !== exp_cont()) begin
        n_fail++; $display("FAIL vec c%0d: got %h %h %b expected %h %h %b", c, alu_a, alu_b, alu_cont, exp_a(), exp_b(), exp_cont());
      end
      step();
    end
    n_checks++; if (vec_cnt !== 16'd20) begin n_fail++; $display("FAIL vec_cnt20: got %0d expected 20", vec_cnt); end
    n_checks++; if (rep_enable !== 8'hFF) begin n_fail++; $display("FAIL clean_en: got %h expected ff", rep_enable); end
  endtask

  task automatic test_cpu_preempt();
    logic [31:0] saved;
    saved = m_lfsr;
    drive(1, 32'h12345678, 32'h9ABCDEF0, 3'b110, 1);
    #1;
    n_checks++; if (alu_a !== 32'h12345678 || alu_b !== 32'h9ABCDEF0 || alu_cont !== 3'b110 || cpu_owns !== 1'b1) begin
      n_fail++; $display("FAIL cpu_mux: got %h %h %b owns %b expected 12345678 9abcdef0 110 1", alu_a, alu_b, alu_cont, cpu_owns);
    end
    step();
    n_checks++; if (vec_cnt !== 16'd20) begin n_fail++; $display("FAIL cpu_vec_hold: got %0d expected 20", vec_cnt); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1);
      #1;
      n_checks++; if (alu_a !== 32'd0 || cpu_owns !== 1'b0) begin n_fail++; $display("FAIL rewait c%0d: got %h owns %b expected 0 0", k, alu_a, cpu_owns); end
      step();
    end
    drive(0, 0, 0, 0, 1);
    #1;
    n_checks++; if (alu_a !== saved || alu_cont !== exp_cont()) begin
      n_fail++; $display("FAIL resume_vec: got %h/%b expected %h/%b", alu_a, alu_cont, saved, exp_cont());
    end
    step();
    n_checks++; if (vec_cnt !== 16'd21) begin n_fail++; $display("FAIL resume_cnt: got %0d expected 21", vec_cnt); end
  endtask

  task automatic test_single_fault();
    assert_reset(); release_reset();
    idle_cycles(IDLE_WAIT);
    kind[5] = 1;
    idle_cycles(1);
    n_checks++; if (rep_enable !== 8'hFF) begin n_fail++; $display("FAIL rep5_first: got %h expected ff", rep_enable); end
    idle_cycles(1);
    n_checks++; if (rep_enable !== 8'hDF || fault_cnt !== 4'd1) begin n_fail++; $display("FAIL rep5_off: got %h/%0d expected df/1", rep_enable, fault_cnt); end
    idle_cycles(3);
    n_checks++; if (rep_enable !== 8'hDF || degraded !== 1'b0) begin n_fail++; $display("FAIL rep5_sticky: got %h deg %b expected df 0", rep_enable, degraded); end
  endtask

  task automatic test_transient();
    assert_reset(); release_reset();
    idle_cycles(IDLE_WAIT);
    kind[2] = 1; idle_cycles(1);
    kind[2] = 0; idle_cycles(1);
    kind[2] = 1; idle_cycles(1);
    kind[2] = 0; idle_cycles(2);
    n_checks++; if (rep_enable !== 8'hFF) begin n_fail++; $display("FAIL transient: got %h expected ff", rep_enable); end
    kind[2] = 2; idle_cycles(2);  // zero-flag-only mismatch counts too
    n_checks++; if (rep_enable !== 8'hFB || fault_cnt !== 4'd1) begin n_fail++; $display("FAIL rep2_off: got %h/%0d expected fb/1", rep_enable, fault_cnt); end
  endtask

  task automatic test_min_alive();
    assert_reset(); release_reset();
    idle_cycles(IDLE_WAIT);
    for (int i = 0; i < 5; i++) kind[i] = 1;
    idle_cycles(2);
    n_checks++; if (rep_enable !== 8'hE0 || fault_cnt !== 4'd5 || degraded !== 1'b0) begin
      n_fail++; $display("FAIL five_off: got %h/%0d deg %b expected e0/5 0", rep_enable, fault_cnt, degraded);
    end
    kind[5] = 1;
    idle_cycles(2);
    n_checks++; if (rep_enable !== 8'hE0 || fault_cnt !== 4'd5 || degraded !== 1'b1) begin
      n_fail++; $display("FAIL min_alive: got %h/%0d deg %b expected e0/5 1", rep_enable, fault_cnt, degraded);
    end
  endtask

  task automatic test_reset_mid();
    assert_reset(); release_reset();
    idle_cycles(IDLE_WAIT);
    kind[5] = 1;
    idle_cycles(3);
    n_checks++; if (rep_enable !== 8'hDF) begin n_fail++; $display("FAIL pre_reset: got %h expected df", rep_enable); end
    assert_reset();
    n_checks++; if (rep_enable !== 8'hFF || vec_cnt !== 16'd0 || degraded !== 1'b0 || alu_a !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: en %h vec %0d deg %b a %h expected ff 0 0 0", rep_enable, vec_cnt, degraded, alu_a);
    end
    release_reset();
    idle_cycles(IDLE_WAIT);
    drive(0, 0, 0, 0, 1);
    #1;
    n_checks++; if (alu_a !== 32'hACE12345 || alu_cont !== 3'b010) begin n_fail++; $display("FAIL reseed: got %h/%b expected ace12345/010", alu_a, alu_cont); end
    step();
  endtask

  task automatic test_random();
    assert_reset(); release_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(31) == 0) kind[$urandom_range(NREP - 1)] = int'($urandom_range(2));
      drive($urandom_range(3) == 0, $urandom, $urandom, 3'($urandom_range(7)), $urandom_range(15) != 0);
      #1;
      n_checks++; if (alu_a !== exp_a() || alu_b !== exp_b() || alu_cont !== exp_cont() || cpu_owns !== cpu_valid) begin
        n_fail++; $display("FAIL rnd_bus c%0d: got %h %h %b %b expected %h %h %b %b", c, alu_a, alu_b, alu_cont, cpu_owns, exp_a(), exp_b(), exp_cont(), cpu_valid);
      end
      step();
      n_checks++; if (rep_enable !== m_en || vec_cnt !== 16'(m_vec) || degraded !== m_deg || fault_cnt !== 4'($countones(~m_en))) begin
        n_fail++; $display("FAIL rnd_state c%0d: got en %h vec %0d deg %b fc %0d expected en %h vec %0d deg %b", c, rep_enable, vec_cnt, degraded, fault_cnt, m_en, m_vec, m_deg);
      end
    end
  endtask

  initial begin
    OPS[0] = 3'b010; OPS[1] = 3'b110; OPS[2] = 3'b000; OPS[3] = 3'b001; OPS[4] = 3'b111;
    for (int i = 0; i < NREP; i++) kind[i] = 0;
    rep_result = '0; rep_zero = '0;
    test_reset();
    test_first_vector();
    test_cpu_preempt();
    test_single_fault();
    test_transient();
    test_min_alive();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_selftest_sched.md
Name: alu_selftest_sched

Overview:
- Online self-test scheduler for the 8-replica voted ALU bank.
- Sits between the processor datapath and the replica operand inputs. The processor always has priority.
- After the processor has been idle for a set number of cycles, the block issues pseudo-random test vectors to all replicas and checks each replica against a built-in golden model.
- A replica that fails repeatedly is removed from the vote through a sticky enable mask.

Parameters:
NREP, 8, number of ALU replicas
IDLE_WAIT, 4, consecutive idle cycles before testing starts (>=1)
FAIL_LIMIT, 2, consecutive mismatches that disable a replica (1..3)
MIN_ALIVE, 3, minimum replicas left enabled
LFSR_SEED, 32'hACE12345, LFSR reset value (nonzero)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cpu_valid  in  1  processor drives the ALU this cycle
cpu_a  in  32  processor operand a
cpu_b  in  32  processor operand b
cpu_alucont  in  3  processor ALU control
test_en  in  1  self-test permitted
alu_a  out  32  operand a to replicas
alu_b  out  32  operand b to replicas
alu_cont  out  3  ALU control to replicas
cpu_owns  out  1  bank is driven by the processor
rep_result  in  NREP*32  replica i result at [32i+31:32i]
rep_zero  in  NREP  replica zero flags
rep_enable  out  NREP  replica i takes part in the vote when 1
fault_cnt  out  4  popcount of ~rep_enable
degraded  out  1  sticky: a disable was suppressed by MIN_ALIVE
vec_cnt  out  16  completed test vectors, saturating

Behaviour:
- Reset is asynchronous, active-high, clock clk. On reset, all state returns immediately:
  - state=WAIT, idle_cnt=0, lfsr=LFSR_SEED, op_idx=0.
  - Per-replica mismatch counters = 0.
  - rep_enable = all ones, degraded=0, vec_cnt=0, fault_cnt=0.
- Operand mux (combinational, zero latency):
  - cpu_valid=1: alu_* = cpu_*, cpu_owns=1. This holds in any state.
  - Else, state TEST with test_en=1: alu_* = test vector.
  - Otherwise: alu_* = 0.
  - cpu_owns = cpu_valid.
- Test vector:
  - a = lfsr; b = {lfsr[15:0], lfsr[31:16]}.
  - alu_cont selected by op_idx 0..4: 3'b010, 3'b110, 3'b000, 3'b001, 3'b111.
- Golden model:
  - b2 = cont[2] ? ~b : b; sum = a + b2 + cont[2] (mod 2^32).
  - cont[1:0]: 00 → a&b; 01 → a|b; 10 → sum; 11 → {31'b0, sum[31]}.
  - gzero = (result == 0).
- FSM:
  - WAIT:
    - If cpu_valid or !test_en: idle_cnt <= 0.
    - Else if idle_cnt == IDLE_WAIT-1: go to TEST, idle_cnt <= 0.
    - Else: idle_cnt++.
  - TEST:
    - If cpu_valid or !test_en: go to WAIT, idle_cnt <= 0. No check, lfsr and op_idx unchanged.
    - Else, one vector checks at the clock edge:
      - lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
      - op_idx <= (op_idx==4) ? 0 : op_idx+1.
      - vec_cnt++ (saturates at 16'hFFFF).
      - Stay in TEST.
- Check for replica i (all replicas checked, enabled or not):
  - Mismatch = rep_result[i] != golden, or rep_zero[i] != gzero.
  - On mismatch, counter i saturates-increments; on match, counter i <= 0.
  - Candidate = enabled, and counter would reach FAIL_LIMIT this cycle.
- Disable:
  - If (enabled count − candidate count) >= MIN_ALIVE: clear all candidates' rep_enable bits in the same edge.
  - Else: disable none and set degraded=1.
  - rep_enable bits never re-set except by reset.
- First vector latency: TEST is entered IDLE_WAIT cycles after idle begins, and the first vector is on alu_* in that TEST cycle.
- Reset mid-TEST: outputs take their reset values asynchronously, and the vector in flight is discarded.

Test Plan:
- Reset, then hold cpu_valid=0, test_en=1, all replicas modeled correct → cycles 0..3 show alu_a=0. Cycle 4 shows alu_a=32'hACE12345, alu_cont=3'b010. After 20 test cycles, vec_cnt=20 and rep_enable=8'hFF.
- cpu_valid=1 for 1 cycle mid-TEST with cpu_a=32'h12345678 → alu_a=32'h12345678 and cpu_owns=1 in the same cycle. vec_cnt unchanged for that cycle. The next test vector repeats the interrupted lfsr value, 4 idle cycles after cpu_valid falls.
- Replica 5 returns ~golden on every vector → after 2 TEST cycles, rep_enable=8'hDF and fault_cnt=1. Other replicas are untouched.
- Replica 2 wrong on one vector only, then correct → its counter returns to 0 and rep_enable stays 8'hFF. Replica 2 then wrong on 2 consecutive vectors → rep_enable=8'hFB.
- Replicas 0–4 forced faulty → rep_enable=8'hE0 and fault_cnt=5 after 2 vectors. Then replica 5 is also faulted → it stays enabled, degraded=1, fault_cnt stays 5.
- Assert reset for 1 cycle mid-TEST with rep_enable=8'hDF → immediately rep_enable=8'hFF, vec_cnt=0, degraded=0, alu_a=0. Testing resumes with seed 32'hACE12345.
